// File: rtl/rx_iq_collect_pkg.sv
// Shared constants, word-pointer states and word-layout helper for the RX IQ collector.
// Used by rx_iq_chan and rx_iq_collect (optional overrun reporting: RX_IQ_OVERRUN_EN).
package rx_iq_collect_pkg;

  localparam int RX_IQ_BITS  = 24;
  localparam int RX_IQ_WORDS = 3;
  localparam int RX_WORD_W   = 16;

  // Bit positions of each 16-bit readout word within the 24-bit I/Q pair
  localparam int W0_I_LSB = 0;
  localparam int W1_Q_LSB = 0;
  localparam int W1_I_LSB = 16;
  localparam int W1_PART  = 8;
  localparam int W2_Q_LSB = 8;

  typedef enum logic [$clog2(RX_IQ_WORDS)-1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2
  } word_ptr_e;

  function automatic logic [RX_WORD_W-1:0] word_sel(
    input word_ptr_e             ptr,
    input logic [RX_IQ_BITS-1:0] i_val,
    input logic [RX_IQ_BITS-1:0] q_val
  );
    case (ptr)
      W0:      return i_val[W0_I_LSB +: RX_WORD_W];
      W1:      return {q_val[W1_Q_LSB +: W1_PART], i_val[W1_I_LSB +: W1_PART]};
      default: return q_val[W2_Q_LSB +: RX_WORD_W];
    endcase
  endfunction

endpackage

// File: rtl/rx_iq_chan.sv
// One receiver channel: holding pair + valid bit, output pair loaded on a set
// completion, and the W0/W1/W2 readout pointer driving a zero-latency word mux.
module rx_iq_chan
  import rx_iq_collect_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stb_i,
  input  logic [RX_IQ_BITS-1:0] i_i,
  input  logic [RX_IQ_BITS-1:0] q_i,
  input  logic                  load_i,
  input  logic                  get_i_i,
  input  logic                  get_q_i,
  output logic                  valid_o,
  output logic [RX_WORD_W-1:0]  word_o
);

  logic [RX_IQ_BITS-1:0] hold_i_q, hold_q_q;
  logic [RX_IQ_BITS-1:0] out_i_q, out_q_q;
  logic                  valid_q;
  word_ptr_e             ptr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_i_q <= '0;
      hold_q_q <= '0;
      out_i_q  <= '0;
      out_q_q  <= '0;
      valid_q  <= 1'b0;
      ptr_q    <= W0;
    end else begin
      if (stb_i) begin
        hold_i_q <= i_i;
        hold_q_q <= q_i;
      end
      // A strobe on the load edge refills the holding pair and stays valid.
      valid_q <= stb_i | (valid_q & ~load_i);

      if (load_i) begin
        out_i_q <= hold_i_q;
        out_q_q <= hold_q_q;
        ptr_q   <= W0;
      end else begin
        case (ptr_q)
          W0:      if (get_i_i) ptr_q <= W1;
          W1:      if (get_q_i && !get_i_i) ptr_q <= W2;
          default: ;
        endcase
      end
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_sel(ptr_q, out_i_q, out_q_q);

endmodule

// File: rtl/rx_iq_collect.sv
// Collects one decimated I/Q sample per receiver channel, publishes the complete
// set as 16-bit words per channel. Define RX_IQ_OVERRUN_EN for overrun reporting.
module rx_iq_collect
  import rx_iq_collect_pkg::*;
#(
  parameter  int V_RX_CHANS = 4,
  localparam int RXN_W      = (V_RX_CHANS > 1) ? $clog2(V_RX_CHANS) : 1
) (
  input  logic                             adc_clk,
  input  logic                             reset_A,
  input  logic [V_RX_CHANS-1:0]            iq_stb_A,
  input  logic [V_RX_CHANS*RX_IQ_BITS-1:0] i_A,
  input  logic [V_RX_CHANS*RX_IQ_BITS-1:0] q_A,
  input  logic [RXN_W-1:0]                 rd_rxn_A,
  input  logic                             rd_getI,
  input  logic                             rd_getQ,
  output logic                             rx_avail_A,
  output logic [V_RX_CHANS*RX_WORD_W-1:0]  rxn_din_A,
  output logic [V_RX_CHANS-1:0]            overrun_A,
  output logic [15:0]                      ovr_ctr_A
);

  logic [V_RX_CHANS-1:0] valid;
  logic                  load;
  logic                  rx_avail_q;

  // The load edge is the one following the cycle in which every channel is valid.
  assign load = &valid;

  for (genvar n = 0; n < V_RX_CHANS; n++) begin : g_chan
    rx_iq_chan u_chan (
      .clk_i   (adc_clk),
      .rst_i   (reset_A),
      .stb_i   (iq_stb_A[n]),
      .i_i     (i_A[RX_IQ_BITS*n +: RX_IQ_BITS]),
      .q_i     (q_A[RX_IQ_BITS*n +: RX_IQ_BITS]),
      .load_i  (load),
      .get_i_i (rd_getI && (rd_rxn_A == RXN_W'(n))),
      .get_q_i (rd_getQ && (rd_rxn_A == RXN_W'(n))),
      .valid_o (valid[n]),
      .word_o  (rxn_din_A[RX_WORD_W*n +: RX_WORD_W])
    );
  end

  always_ff @(posedge adc_clk) begin
    if (reset_A) rx_avail_q <= 1'b0;
    else         rx_avail_q <= load;
  end

  assign rx_avail_A = rx_avail_q;

`ifdef RX_IQ_OVERRUN_EN
  logic [V_RX_CHANS-1:0] ovr_hit;
  logic [V_RX_CHANS-1:0] overrun_q;
  logic [15:0]           ovr_ctr_q;

  // A strobe landing on the load edge refills an emptied slot, so it is not an overrun.
  assign ovr_hit = iq_stb_A & valid & {V_RX_CHANS{~load}};

  always_ff @(posedge adc_clk) begin
    if (reset_A) begin
      overrun_q <= '0;
      ovr_ctr_q <= '0;
    end else begin
      overrun_q <= overrun_q | ovr_hit;
      if ((|ovr_hit) && (ovr_ctr_q != 16'hFFFF)) ovr_ctr_q <= ovr_ctr_q + 16'd1;
    end
  end

  assign overrun_A = overrun_q;
  assign ovr_ctr_A = ovr_ctr_q;
`else
  assign overrun_A = '0;
  assign ovr_ctr_A = '0;
`endif

endmodule

// File: tb/tb_rx_iq_collect.sv
// Self-checking bench for rx_iq_collect: directed scenarios plus a randomized run
// compared every cycle against a set-level behavioural model.
module tb_rx_iq_collect;

  localparam int N = 4;

`ifdef RX_IQ_OVERRUN_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  logic adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  logic            reset_A;
  logic [N-1:0]    iq_stb_A;
  logic [N*24-1:0] i_A, q_A;
  logic [1:0]      rd_rxn_A;
  logic            rd_getI, rd_getQ;
  logic            rx_avail_A;
  logic [N*16-1:0] rxn_din_A;
  logic [N-1:0]    overrun_A;
  logic [15:0]     ovr_ctr_A;

  // Second instance with a non-power-of-two channel count, for out-of-range selects
  logic [4:0]      stb5;
  logic [119:0]    i5, q5;
  logic [2:0]      rxn5;
  logic            get_i5, get_q5;
  logic            avail5;
  logic [79:0]     din5;
  logic [4:0]      ovr5;
  logic [15:0]     ctr5;

  rx_iq_collect #(.V_RX_CHANS(N)) dut (
    .adc_clk(adc_clk), .reset_A(reset_A), .iq_stb_A(iq_stb_A), .i_A(i_A), .q_A(q_A),
    .rd_rxn_A(rd_rxn_A), .rd_getI(rd_getI), .rd_getQ(rd_getQ), .rx_avail_A(rx_avail_A),
    .rxn_din_A(rxn_din_A), .overrun_A(overrun_A), .ovr_ctr_A(ovr_ctr_A)
  );

  rx_iq_collect #(.V_RX_CHANS(5)) dut5 (
    .adc_clk(adc_clk), .reset_A(reset_A), .iq_stb_A(stb5), .i_A(i5), .q_A(q5),
    .rd_rxn_A(rxn5), .rd_getI(get_i5), .rd_getQ(get_q5), .rx_avail_A(avail5),
    .rxn_din_A(din5), .overrun_A(ovr5), .ovr_ctr_A(ctr5)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word k of a sample set, written straight from the published layout.
  function automatic logic [15:0] exp_word(input int k, input logic [23:0] iv, input logic [23:0] qv);
    int unsigned i_u, q_u;
    i_u = iv;
    q_u = qv;
    case (k)
      0:       return 16'(i_u % 65536);
      1:       return 16'(((q_u % 256) * 256) + (i_u / 65536));
      default: return 16'(q_u / 256);
    endcase
  endfunction

  // Behavioural model: per-channel holding/output sets, word index, overrun bookkeeping.
  typedef struct packed {
    logic [N-1:0][23:0] hi, hq, oi, oq;
    logic [N-1:0]       valid, ovr;
    logic [N-1:0][1:0]  ptr;
    logic [15:0]        ctr;
    logic               avail;
  } model_t;

  model_t m;

  function automatic model_t next_model(input model_t cur, input logic rst, input logic [N-1:0] stb,
                                        input logic [N*24-1:0] iv, input logic [N*24-1:0] qv,
                                        input logic [1:0] rxn, input logic gi, input logic gq);
    model_t nx;
    bit     set_done, any_ovr;
    if (rst) return '0;
    nx       = cur;
    set_done = (cur.valid == {N{1'b1}});
    any_ovr  = 0;
    for (int c = 0; c < N; c++) begin
      if (stb[c] && cur.valid[c] && !set_done) begin
        nx.ovr[c] = 1'b1;
        any_ovr   = 1;
      end
      if (set_done) begin
        nx.oi[c]    = cur.hi[c];
        nx.oq[c]    = cur.hq[c];
        nx.ptr[c]   = 2'd0;
        nx.valid[c] = 1'b0;
      end else if (int'(rxn) == c) begin
        if (gi) begin
          if (cur.ptr[c] == 2'd0) nx.ptr[c] = 2'd1;
        end else if (gq && cur.ptr[c] == 2'd1) begin
          nx.ptr[c] = 2'd2;
        end
      end
      if (stb[c]) begin
        nx.hi[c]    = iv[24*c +: 24];
        nx.hq[c]    = qv[24*c +: 24];
        nx.valid[c] = 1'b1;
      end
    end
    if (any_ovr && cur.ctr != 16'hFFFF) nx.ctr = cur.ctr + 16'd1;
    nx.avail = set_done;
    return nx;
  endfunction

  always @(posedge adc_clk)
    m <= next_model(m, reset_A, iq_stb_A, i_A, q_A, rd_rxn_A, rd_getI, rd_getQ);

  bit cmp_en = 1'b0;

  always @(negedge adc_clk) begin
    if (cmp_en) begin
      check("avail", rx_avail_A, m.avail);
      for (int c = 0; c < N; c++)
        check($sformatf("word_ch%0d", c), rxn_din_A[16*c +: 16],
              exp_word(int'(m.ptr[c]), m.oi[c], m.oq[c]));
      check("overrun", overrun_A, OVR_ON ? m.ovr : '0);
      check("ovr_ctr", ovr_ctr_A, OVR_ON ? m.ctr : 16'd0);
    end
  end

  logic [23:0] si [N];
  logic [23:0] sq [N];
  logic [23:0] s5i [5];
  logic [23:0] s5q [5];
  int          pulses;

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic idle();
    iq_stb_A = '0;
    rd_getI  = 1'b0;
    rd_getQ  = 1'b0;
  endtask

  task automatic set_chan(input int c, input logic [23:0] iv, input logic [23:0] qv);
    i_A[24*c +: 24] = iv;
    q_A[24*c +: 24] = qv;
    si[c] = iv;
    sq[c] = qv;
  endtask

  task automatic strobe_all();
    for (int c = 0; c < N; c++) set_chan(c, 24'($urandom), 24'($urandom));
    iq_stb_A = '1;
  endtask

  function automatic logic [15:0] din(input int c);
    return rxn_din_A[16*c +: 16];
  endfunction

  initial begin
    reset_A = 1'b1;
    idle();
    rd_rxn_A = '0;
    i_A = '0;
    q_A = '0;
    stb5 = '0; i5 = '0; q5 = '0; rxn5 = '0; get_i5 = 1'b0; get_q5 = 1'b0;
    tick();
    tick();
    cmp_en = 1'b1;
    check("reset_avail", rx_avail_A, 1'b0);
    check("reset_din", rxn_din_A, '0);
    reset_A = 1'b0;

    // Staggered strobes, ch3 last with a known sample
    for (int c = 0; c < N - 1; c++) begin
      set_chan(c, 24'($urandom), 24'($urandom));
      iq_stb_A = N'(1 << c);
      tick();
    end
    set_chan(3, 24'h123456, 24'hABCDEF);
    iq_stb_A = 4'b1000;
    tick();
    idle();
    check("s1_no_early_avail", rx_avail_A, 1'b0);
    tick();
    check("s1_avail", rx_avail_A, 1'b1);
    check("s1_ch3_w0", din(3), 16'h3456);
    tick();
    check("s1_avail_once", rx_avail_A, 1'b0);
    rd_rxn_A = 2'd3;
    rd_getI  = 1'b1;
    tick();
    idle();
    check("s1_ch3_w1", din(3), 16'hEF12);
    rd_getQ = 1'b1;
    tick();
    idle();
    check("s1_ch3_w2", din(3), 16'hABCD);

    // Fresh set, then readout of ch2 only
    strobe_all();
    tick();
    idle();
    tick();
    rd_rxn_A = 2'd2;
    check("s2_ch2_w0", din(2), exp_word(0, si[2], sq[2]));
    rd_getI = 1'b1;
    tick();
    rd_getI = 1'b0;
    rd_getQ = 1'b1;
    check("s2_ch2_w1", din(2), exp_word(1, si[2], sq[2]));
    tick();
    idle();
    check("s2_ch2_w2", din(2), exp_word(2, si[2], sq[2]));
    check("s2_ch0_w0", din(0), exp_word(0, si[0], sq[0]));
    check("s2_ch1_w0", din(1), exp_word(0, si[1], sq[1]));
    check("s2_ch3_w0", din(3), exp_word(0, si[3], sq[3]));

    // getQ while at W0 is ignored
    rd_rxn_A = 2'd0;
    rd_getQ  = 1'b1;
    tick();
    idle();
    check("s6_getq_at_w0", din(0), exp_word(0, si[0], sq[0]));

    // Double strobe on ch1 before the set completes
    set_chan(1, 24'h111111, 24'h222222);
    iq_stb_A = 4'b0010;
    tick();
    set_chan(1, 24'h654321, 24'h0FEDCB);
    tick();
    idle();
    check("s3_overrun", overrun_A, OVR_ON ? 4'b0010 : 4'b0000);
    check("s3_ovr_ctr", ovr_ctr_A, OVR_ON ? 16'd1 : 16'd0);
    set_chan(0, 24'($urandom), 24'($urandom));
    set_chan(2, 24'($urandom), 24'($urandom));
    set_chan(3, 24'($urandom), 24'($urandom));
    iq_stb_A = 4'b1101;
    tick();
    idle();
    tick();
    check("s3_avail", rx_avail_A, 1'b1);
    check("s3_ch1_second", din(1), 16'h4321);

    // Two full simultaneous strobes with a load in between
    pulses = 0;
    strobe_all();
    tick();
    pulses += int'(rx_avail_A);
    idle();
    repeat (2) begin tick(); pulses += int'(rx_avail_A); end
    strobe_all();
    tick();
    pulses += int'(rx_avail_A);
    idle();
    repeat (3) begin tick(); pulses += int'(rx_avail_A); end
    check("s4_pulses", pulses, 2);
    check("s4_ovr_ctr", ovr_ctr_A, OVR_ON ? 16'd1 : 16'd0);
    check("s4_overrun", overrun_A, OVR_ON ? 4'b0010 : 4'b0000);

    // Reset in the middle of a readout, with strobes present in the reset cycle
    rd_rxn_A = 2'd0;
    rd_getI  = 1'b1;
    tick();
    idle();
    check("s5_ch0_w1", din(0), exp_word(1, si[0], sq[0]));
    reset_A = 1'b1;
    strobe_all();
    tick();
    check("s5_din_zero", rxn_din_A, '0);
    check("s5_avail_zero", rx_avail_A, 1'b0);
    check("s5_overrun_zero", overrun_A, '0);
    check("s5_ctr_zero", ovr_ctr_A, '0);
    reset_A = 1'b0;
    idle();
    tick();
    check("s5_strobe_ignored_a", rx_avail_A, 1'b0);
    tick();
    check("s5_strobe_ignored_b", rx_avail_A, 1'b0);

    // Out-of-range channel select on the five-channel instance
    for (int c = 0; c < 5; c++) begin
      s5i[c] = 24'($urandom);
      s5q[c] = 24'($urandom);
      i5[24*c +: 24] = s5i[c];
      q5[24*c +: 24] = s5q[c];
    end
    stb5 = 5'h1F;
    tick();
    stb5 = '0;
    tick();
    check("s6_dut5_avail", avail5, 1'b1);
    rxn5   = 3'd5;
    get_i5 = 1'b1;
    tick();
    rxn5 = 3'd7;
    tick();
    get_i5 = 1'b0;
    for (int c = 0; c < 5; c++)
      check($sformatf("s6_rxn_oor_ch%0d", c), din5[16*c +: 16], exp_word(0, s5i[c], s5q[c]));
    rxn5   = 3'd4;
    get_i5 = 1'b1;
    tick();
    get_i5 = 1'b0;
    check("s6_rxn4_ch4_w1", din5[64 +: 16], exp_word(1, s5i[4], s5q[4]));

    // Randomized traffic against the model
    repeat (3000) begin
      reset_A = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < N; c++) begin
        iq_stb_A[c] = ($urandom_range(0, 2) == 0);
        i_A[24*c +: 24] = 24'($urandom);
        q_A[24*c +: 24] = 24'($urandom);
      end
      rd_rxn_A = 2'($urandom);
      rd_getI  = ($urandom_range(0, 3) == 0);
      rd_getQ  = ($urandom_range(0, 2) == 0);
      tick();
    end
    reset_A = 1'b0;
    idle();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_iq_collect.md
RX_IQ_COLLECT -- requirements
Module: rx_iq_collect

Interface
REQ-001 SHALL have parameter V_RX_CHANS, default 4: number of receiver channels, range 1..16.
REQ-002 SHALL have port adc_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_A, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port iq_stb_A, input, V_RX_CHANS bits: per-channel pulse marking a new decimated sample.
REQ-005 SHALL have port i_A, input, V_RX_CHANS*24 bits: per-channel signed I sample; channel n occupies [24n+23:24n].
REQ-006 SHALL have port q_A, input, V_RX_CHANS*24 bits: per-channel signed Q sample, same packing as i_A.
REQ-007 SHALL have port rd_rxn_A, input, max(1,clog2(V_RX_CHANS)) bits: channel targeted by rd_getI/rd_getQ.
REQ-008 SHALL have port rd_getI, input, 1 bit: advance the selected channel from word 0 to word 1.
REQ-009 SHALL have port rd_getQ, input, 1 bit: advance the selected channel from word 1 to word 2.
REQ-010 SHALL have port rx_avail_A, output, 1 bit: one-cycle pulse when a complete all-channel sample set is loaded.
REQ-011 SHALL have port rxn_din_A, output, V_RX_CHANS*16 bits: current 16-bit word per channel; channel n occupies [16n+15:16n].
REQ-012 SHALL have port overrun_A, output, V_RX_CHANS bits: sticky per-channel overrun flags.
REQ-013 SHALL have port ovr_ctr_A, output, 16 bits: total overrun count.

Function
REQ-014 Each channel SHALL have a holding register pair (I, Q) and a valid bit; on iq_stb_A[n] it SHALL capture i_A and q_A for n and set valid[n].
REQ-015 If iq_stb_A[n] arrives while valid[n] is already set, the block SHALL overwrite the holding pair, set overrun_A[n], and increment ovr_ctr_A by one (saturating at 0xFFFF).
- If several channels overrun in the same cycle, ovr_ctr_A SHALL increase by 1 only.
REQ-016 When all valid bits are set, the block SHALL in the next cycle:
- copy every holding pair to that channel's output pair;
- clear all valid bits;
- reset every word pointer to 0;
- pulse rx_avail_A for exactly one cycle.
REQ-017 If a strobe for channel n coincides with the load cycle, the new sample SHALL be captured and valid[n] SHALL end the cycle set; this is not an overrun.
REQ-018 Word layout per channel SHALL be: word0 = I[15:0]; word1 = {Q[7:0], I[23:16]}; word2 = Q[23:8].
REQ-019 Each channel's pointer SHALL be a state machine with states W0, W1, W2:
- W0->W1 on the edge where rd_getI=1 and rd_rxn_A=n;
- W1->W2 on the edge where rd_getQ=1 and rd_rxn_A=n;
- W2 holds until the next load;
- rd_getQ in W0 and rd_getI in W1 or W2 SHALL be ignored;
- if rd_getI and rd_getQ are both high in one cycle, rd_getI SHALL take priority.
REQ-020 rxn_din_A SHALL be a combinational mux from the registered pointer and output pair, so the word for the current pointer is valid in the same cycle (zero latency).
REQ-021 rd_rxn_A values at or above V_RX_CHANS SHALL affect no channel.
REQ-022 A load (REQ-016) SHALL override any simultaneous rd_getI or rd_getQ.

Reset
REQ-023 reset_A SHALL clear all holding pairs, output pairs, valid bits, pointers (to W0), overrun_A, ovr_ctr_A and rx_avail_A to 0.
- This holds even mid-collection or mid-readout.
- rxn_din_A SHALL read 0 after reset.
- Strobes in the reset cycle SHALL be ignored.

Configuration
REQ-024 Macro RX_IQ_OVERRUN_EN SHALL gate overrun reporting.
- When defined: overrun_A and ovr_ctr_A behave per REQ-015.
- When undefined: both ports are constant 0, no counter logic is synthesized, and data behaviour is unchanged.

Structure
REQ-025 Constants RX_IQ_BITS=24, RX_IQ_WORDS=3 and the word-layout bit positions SHALL live in the shared kiwi include.
REQ-026 A per-channel sub-module rx_iq_chan SHALL hold the holding pair, valid bit, output pair, pointer FSM and word mux; rx_iq_collect SHALL generate V_RX_CHANS instances plus the all-valid detect, load pulse and overrun counter.

Verification
REQ-027 The bench SHALL cover these directed scenarios (V_RX_CHANS=4):
- Strobe ch0..3 in different cycles, ch3 last with I=0x123456, Q=0xABCDEF -> rx_avail_A pulses once, one cycle after ch3's strobe; ch3 words read 0x3456, 0xEF12, 0xABCD.
- Readout with rd_rxn_A=2: rd_getI then rd_getQ in consecutive cycles -> ch2 word sequence W0, W1, W2 across three cycles; channels 0, 1 and 3 stay at W0.
- Two ch1 strobes before the set completes (build with RX_IQ_OVERRUN_EN) -> overrun_A=4'b0010, ovr_ctr_A=1, ch1 output holds the second sample.
- All four channels strobed in the same cycle, twice, with a load in between -> no overrun; two rx_avail_A pulses.
- reset_A asserted mid-readout with ch0 at W1 -> next cycle all rxn_din_A=0, all pointers at W0, rx_avail_A=0.
- rd_getQ at W0, and rd_rxn_A=5 -> no pointer movement.
